// File: rtl/motion_segmenter.sv
// motion_segmenter: splits one signed relative (dx, dy) move into segments of
// at most SEG_MAX steps per axis. Each segment goes to the XY stepper
// controller over its trigger/done/rdy handshake. Completion is reported
// upstream once the last segment has finished.
// Optional feature: define MOTION_SEGMENTER_ABORT_EN to add an abort input.

`ifndef STEPPER_PULSE_NUM_X_BITS
`define STEPPER_PULSE_NUM_X_BITS 16
`endif
`ifndef STEPPER_PULSE_NUM_Y_BITS
`define STEPPER_PULSE_NUM_Y_BITS 16
`endif
`ifndef STEPPER_PULSE_WIDTH_BITS
`define STEPPER_PULSE_WIDTH_BITS 16
`endif

module motion_segmenter #(
    parameter int MOVE_BITS        = 16,
    parameter int PULSE_NUM_X_BITS = `STEPPER_PULSE_NUM_X_BITS,
    parameter int PULSE_NUM_Y_BITS = `STEPPER_PULSE_NUM_Y_BITS,
    parameter int PULSE_WIDTH_BITS = `STEPPER_PULSE_WIDTH_BITS,
    parameter int SEG_MAX          = 100
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic                               trigger,
    input  logic signed [MOVE_BITS-1:0]        dx,
    input  logic signed [MOVE_BITS-1:0]        dy,
    input  logic        [PULSE_WIDTH_BITS-1:0] pulse_width,
`ifdef MOTION_SEGMENTER_ABORT_EN
    input  logic                               abort,
`endif
    output logic                               rdy,
    output logic                               done,
    output logic                               stp_trigger,
    output logic        [PULSE_WIDTH_BITS-1:0] stp_pulse_width,
    output logic signed [PULSE_NUM_X_BITS-1:0] stp_pulse_num_x,
    output logic signed [PULSE_NUM_Y_BITS-1:0] stp_pulse_num_y,
    input  logic                               stp_done,
    input  logic                               stp_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [MOVE_BITS-1:0] SEG_LIM = MOVE_BITS'(SEG_MAX);

    state_t                        state;
    logic signed [MOVE_BITS-1:0]   rem_x, rem_y;
    logic signed [MOVE_BITS-1:0]   seg_x, seg_y;
    logic signed [MOVE_BITS-1:0]   chunk_x, chunk_y;
    logic [PULSE_WIDTH_BITS-1:0]   pw_q;
    logic                          stop_req;

    // Magnitude is taken as unsigned so that the most negative move is legal.
    function automatic logic signed [MOVE_BITS-1:0] clamp_chunk(
        input logic signed [MOVE_BITS-1:0] rem
    );
        logic [MOVE_BITS-1:0] mag;
        mag = rem[MOVE_BITS-1] ? $unsigned(-rem) : $unsigned(rem);
        if (mag > SEG_LIM) mag = SEG_LIM;
        return rem[MOVE_BITS-1] ? -$signed(mag) : $signed(mag);
    endfunction

    // Per-axis segment size, clamped independently.
    always_comb begin
        chunk_x = clamp_chunk(rem_x);
        chunk_y = clamp_chunk(rem_y);
    end

`ifdef MOTION_SEGMENTER_ABORT_EN
    logic abort_pending;

    // Abort request: live input or one remembered while a segment was in flight.
    always_comb begin
        stop_req = abort || abort_pending;
    end
`else
    // Without the abort feature every segment is always issued.
    always_comb begin
        stop_req = 1'b0;
    end
`endif

    // Segmenting FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            rdy             <= 1'b1;
            done            <= 1'b1;
            stp_trigger     <= 1'b0;
            stp_pulse_width <= '0;
            stp_pulse_num_x <= '0;
            stp_pulse_num_y <= '0;
            rem_x           <= '0;
            rem_y           <= '0;
            seg_x           <= '0;
            seg_y           <= '0;
            pw_q            <= '0;
`ifdef MOTION_SEGMENTER_ABORT_EN
            abort_pending   <= 1'b0;
`endif
        end else if (clk_en) begin
            // NOTE: non-blocking assignments make every branch read the
            // pre-edge register values, so ISSUE subtracts the segment that
            // was actually sent, not one recomputed mid-update.
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        rem_x <= dx;
                        rem_y <= dy;
                        pw_q  <= pulse_width;
                        rdy   <= 1'b0;
                        done  <= 1'b0;
`ifdef MOTION_SEGMENTER_ABORT_EN
                        abort_pending <= 1'b0;
`endif
                        state <= (dx == '0 && dy == '0) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    if (stop_req) begin
                        rem_x <= '0;
                        rem_y <= '0;
                        state <= S_FINISH;
                    end else begin
                        seg_x           <= chunk_x;
                        seg_y           <= chunk_y;
                        stp_pulse_num_x <= PULSE_NUM_X_BITS'(chunk_x);
                        stp_pulse_num_y <= PULSE_NUM_Y_BITS'(chunk_y);
                        stp_pulse_width <= pw_q;
                        stp_trigger     <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MOTION_SEGMENTER_ABORT_EN
                    if (abort) abort_pending <= 1'b1;
`endif
                    if (!stp_done) begin
                        stp_trigger <= 1'b0;
                        rem_x       <= rem_x - seg_x;
                        rem_y       <= rem_y - seg_y;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
`ifdef MOTION_SEGMENTER_ABORT_EN
                    if (abort) abort_pending <= 1'b1;
`endif
                    if (stp_rdy) begin
                        if ((rem_x == '0 && rem_y == '0) || stop_req) begin
                            rem_x <= '0;
                            rem_y <= '0;
                            state <= S_FINISH;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_FINISH: begin
                    if (!trigger) begin
                        rdy   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
